// File: rtl/dmem_pkg.sv
// Shared types, preload image and address decoding for the wait-state data memory.
package dmem_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  localparam logic [15:0] PRELOAD_0 = 16'h2BCD;
  localparam logic [15:0] PRELOAD_1 = 16'h0000;
  localparam logic [15:0] PRELOAD_2 = 16'h1234;
  localparam logic [15:0] PRELOAD_3 = 16'hDEAD;
  localparam logic [15:0] PRELOAD_4 = 16'hBEEF;

  typedef struct packed {
    logic [31:0] index;
    logic        misalign;
  } addr_info_t;

  // Splits a byte address into a word index and a flag for nonzero low bits.
  function automatic addr_info_t addr_decode(input logic [31:0] addr, input int lsb_bits);
    addr_info_t  info;
    logic [31:0] mask;
    mask          = (32'd1 << lsb_bits) - 32'd1;
    info.index    = addr >> lsb_bits;
    info.misalign = |(addr & mask);
    return info;
  endfunction

  function automatic logic [15:0] preload_word(input int idx);
    case (idx)
      0:       return PRELOAD_0;
      1:       return PRELOAD_1;
      2:       return PRELOAD_2;
      3:       return PRELOAD_3;
      4:       return PRELOAD_4;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with byte-enabled synchronous write, registered read and reset preload.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic                re,
  input  logic                clr,
  input  logic [IDX_W-1:0]    index,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array is reset on purpose because the pipeline relies on the
  // preload image; this prevents RAM-macro inference, which is acceptable at
  // this depth. Sequential state uses non-blocking assignments so every
  // register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(preload_word(i));
      end
      rdata <= '0;
    end else begin
      if (we) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be[b]) mem[index][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      if (re) begin
        rdata <= mem[index];
      end else if (clr) begin
        rdata <= '0;
      end
    end
  end

endmodule

// File: rtl/data_memory_ws.sv
// MEM-stage data memory with programmable wait states, busy/done handshake and error flags.
module data_memory_ws
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wrtData,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic                MemRead,
  input  logic                MemWrt,
  output logic [DATA_W-1:0]   readData,
  output logic                busy,
  output logic                done,
  output logic                misalign_err,
  output logic                range_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int LSB_W = $clog2(BE_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state, next_state;
  logic [3:0]        cnt, next_cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic [BE_W-1:0]   lat_be;
  logic              lat_wr;

  logic              accept, exec, use_live;
  logic [ADDR_W-1:0] ex_addr;
  logic [DATA_W-1:0] ex_data;
  logic [BE_W-1:0]   ex_be;
  logic              ex_wr;
  addr_info_t        info;
  logic              out_of_range;
  logic              mem_we, mem_re, mem_clr;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    accept     = 1'b0;
    exec       = 1'b0;
    use_live   = 1'b0;

    case (state)
      IDLE: begin
        if (MemWrt || MemRead) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            exec     = 1'b1;
            use_live = 1'b1;
          end else begin
            next_state = WAIT;
            next_cnt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt != 4'd0) begin
          next_cnt = cnt - 4'd1;
        end else begin
          exec       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase

    // Zero-wait builds execute straight off the ports; otherwise off the latched request.
    ex_addr = use_live ? address : lat_addr;
    ex_data = use_live ? wrtData : lat_data;
    ex_be   = use_live ? byte_en : lat_be;
    ex_wr   = use_live ? MemWrt  : lat_wr;

    info         = addr_decode(32'(ex_addr), LSB_W);
    out_of_range = (info.index >= 32'(DEPTH));

    // A misaligned access never touches storage, even when also out of range.
    mem_we  = exec &&  ex_wr && !info.misalign && !out_of_range;
    mem_re  = exec && !ex_wr && !info.misalign && !out_of_range;
    mem_clr = exec && !ex_wr && !info.misalign &&  out_of_range;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      misalign_err <= 1'b0;
      range_err    <= 1'b0;
      lat_addr     <= '0;
      lat_data     <= '0;
      lat_be       <= '0;
      lat_wr       <= 1'b0;
    end else begin
      state        <= next_state;
      cnt          <= next_cnt;
      busy         <= (next_state == WAIT);
      done         <= exec;
      misalign_err <= exec && info.misalign;
      range_err    <= exec && out_of_range;
      if (accept) begin
        lat_addr <= address;
        lat_data <= wrtData;
        lat_be   <= byte_en;
        lat_wr   <= MemWrt;
      end
    end
  end

  dmem_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk  (clk),
    .rst_n(rst),
    .we   (mem_we),
    .re   (mem_re),
    .clr  (mem_clr),
    .index(info.index[IDX_W-1:0]),
    .wdata(ex_data),
    .be   (ex_be),
    .rdata(readData)
  );

endmodule

// File: tb/tb_data_memory_ws.sv
// Directed bench: a WAIT_CYCLES=2 instance for most scenarios, a WAIT_CYCLES=0 instance for back-to-back.
module tb_data_memory_ws;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [15:0] address = '0, wrtData = '0;
  logic [1:0]  byte_en = '0;
  logic        MemRead = 1'b0, MemWrt = 1'b0;
  logic [15:0] readData;
  logic        busy, done, misalign_err, range_err;

  logic [15:0] z_address = '0, z_wrtData = '0;
  logic [1:0]  z_byte_en = '0;
  logic        z_MemRead = 1'b0, z_MemWrt = 1'b0;
  logic [15:0] z_readData;
  logic        z_busy, z_done, z_misalign_err, z_range_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_memory_ws #(.DATA_W(16), .ADDR_W(16), .DEPTH(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .address(address), .wrtData(wrtData), .byte_en(byte_en),
    .MemRead(MemRead), .MemWrt(MemWrt), .readData(readData), .busy(busy), .done(done),
    .misalign_err(misalign_err), .range_err(range_err)
  );

  data_memory_ws #(.DATA_W(16), .ADDR_W(16), .DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .address(z_address), .wrtData(z_wrtData), .byte_en(z_byte_en),
    .MemRead(z_MemRead), .MemWrt(z_MemWrt), .readData(z_readData), .busy(z_busy), .done(z_done),
    .misalign_err(z_misalign_err), .range_err(z_range_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request on the wait-state instance and holds it until done or a 20-edge budget.
  // lat is the edge offset of done relative to the accepting edge, -1 on timeout.
  task automatic access(input logic wr, input logic rd, input logic [15:0] addr,
                        input logic [15:0] data, input logic [1:0] be,
                        output int lat, output int busy_cycles, output logic mis, output logic rng);
    MemWrt  = wr;
    MemRead = rd;
    address = addr;
    wrtData = data;
    byte_en = be;
    lat = -1; busy_cycles = 0; mis = 1'b0; rng = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy) busy_cycles++;
      if (done) begin
        lat = i;
        mis = misalign_err;
        rng = range_err;
        break;
      end
    end
    MemWrt  = 1'b0;
    MemRead = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #10;
    n_checks++; if (readData !== 16'h0000) begin n_fail++; $display("FAIL reset_readData: got %h expected 0000", readData); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if ({misalign_err, range_err} !== 2'b00) begin n_fail++; $display("FAIL reset_errs: got %b expected 00", {misalign_err, range_err}); end
    n_checks++; if (z_readData !== 16'h0000) begin n_fail++; $display("FAIL reset_z_readData: got %h expected 0000", z_readData); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_read_latency();
    int lat, bc; logic mis, rng;
    access(1'b0, 1'b1, 16'h0006, 16'h0000, 2'b00, lat, bc, mis, rng);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL rd_latency: got %0d expected 2", lat); end
    n_checks++; if (bc !== 2) begin n_fail++; $display("FAIL rd_busy_cycles: got %0d expected 2", bc); end
    n_checks++; if (readData !== 16'hDEAD) begin n_fail++; $display("FAIL rd_data: got %h expected DEAD", readData); end
    n_checks++; if ({mis, rng} !== 2'b00) begin n_fail++; $display("FAIL rd_errs: got %b expected 00", {mis, rng}); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rd_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_byte_enable();
    int lat, bc; logic mis, rng;
    access(1'b1, 1'b0, 16'h0004, 16'hA5A5, 2'b01, lat, bc, mis, rng);
    n_checks++; if (readData !== 16'hDEAD) begin n_fail++; $display("FAIL be_wr_readData: got %h expected DEAD", readData); end
    access(1'b0, 1'b1, 16'h0004, 16'h0000, 2'b00, lat, bc, mis, rng);
    n_checks++; if (readData !== 16'h12A5) begin n_fail++; $display("FAIL be_lo_byte: got %h expected 12A5", readData); end
    access(1'b1, 1'b0, 16'h0004, 16'hFFFF, 2'b00, lat, bc, mis, rng);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL be_none_done: got latency %0d expected 2", lat); end
    access(1'b0, 1'b1, 16'h0004, 16'h0000, 2'b00, lat, bc, mis, rng);
    n_checks++; if (readData !== 16'h12A5) begin n_fail++; $display("FAIL be_none_data: got %h expected 12A5", readData); end
  endtask

  task automatic test_write_priority();
    int lat, bc; logic mis, rng;
    access(1'b1, 1'b1, 16'h0008, 16'hCAFE, 2'b11, lat, bc, mis, rng);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL prio_latency: got %0d expected 2", lat); end
    n_checks++; if (readData !== 16'h12A5) begin n_fail++; $display("FAIL prio_readData: got %h expected 12A5", readData); end
    access(1'b0, 1'b1, 16'h0008, 16'h0000, 2'b00, lat, bc, mis, rng);
    n_checks++; if (readData !== 16'hCAFE) begin n_fail++; $display("FAIL prio_readback: got %h expected CAFE", readData); end
  endtask

  task automatic test_misalign();
    int lat, bc; logic mis, rng;
    access(1'b0, 1'b1, 16'h0003, 16'h0000, 2'b00, lat, bc, mis, rng);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL mis_latency: got %0d expected 2", lat); end
    n_checks++; if ({mis, rng} !== 2'b10) begin n_fail++; $display("FAIL mis_flags: got %b expected 10", {mis, rng}); end
    n_checks++; if (readData !== 16'hCAFE) begin n_fail++; $display("FAIL mis_readData: got %h expected CAFE", readData); end
  endtask

  task automatic test_range();
    int lat, bc; logic mis, rng;
    access(1'b1, 1'b0, 16'd128, 16'h5555, 2'b11, lat, bc, mis, rng);
    n_checks++; if ({mis, rng} !== 2'b01) begin n_fail++; $display("FAIL rng_wr_flags: got %b expected 01", {mis, rng}); end
    n_checks++; if (readData !== 16'hCAFE) begin n_fail++; $display("FAIL rng_wr_readData: got %h expected CAFE", readData); end
    access(1'b0, 1'b1, 16'h0000, 16'h0000, 2'b00, lat, bc, mis, rng);
    n_checks++; if (readData !== 16'h2BCD) begin n_fail++; $display("FAIL rng_no_alias: got %h expected 2BCD", readData); end
    access(1'b0, 1'b1, 16'd126, 16'h0000, 2'b00, lat, bc, mis, rng);
    n_checks++; if (readData !== 16'h0000) begin n_fail++; $display("FAIL rng_last_word: got %h expected 0000", readData); end
    access(1'b0, 1'b1, 16'h0000, 16'h0000, 2'b00, lat, bc, mis, rng);
    access(1'b0, 1'b1, 16'd128, 16'h0000, 2'b00, lat, bc, mis, rng);
    n_checks++; if (readData !== 16'h0000) begin n_fail++; $display("FAIL rng_rd_data: got %h expected 0000", readData); end
    n_checks++; if ({mis, rng} !== 2'b01) begin n_fail++; $display("FAIL rng_rd_flags: got %b expected 01", {mis, rng}); end
  endtask

  task automatic test_reset_abort();
    int lat, bc; logic mis, rng;
    logic done_seen;
    done_seen = 1'b0;
    address = 16'h0000; wrtData = 16'h1111; byte_en = 2'b11; MemWrt = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
    #2 rst = 1'b0;
    #1;
    MemWrt = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_async: got %b expected 0", busy); end
    for (int i = 0; i < 3; i++) begin
      tick();
      done_seen = done_seen | done;
    end
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      done_seen = done_seen | done | busy;
    end
    n_checks++; if (done_seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b expected 0", done_seen); end
    access(1'b0, 1'b1, 16'h0000, 16'h0000, 2'b00, lat, bc, mis, rng);
    n_checks++; if (readData !== 16'h2BCD) begin n_fail++; $display("FAIL abort_readback: got %h expected 2BCD", readData); end
  endtask

  task automatic test_back_to_back();
    z_address = 16'h0000; z_MemRead = 1'b1;
    tick();
    n_checks++; if ({z_done, z_busy} !== 2'b10) begin n_fail++; $display("FAIL b2b_first_hs: got %b expected 10", {z_done, z_busy}); end
    n_checks++; if (z_readData !== 16'h2BCD) begin n_fail++; $display("FAIL b2b_first_data: got %h expected 2BCD", z_readData); end
    z_address = 16'h0002;
    tick();
    n_checks++; if ({z_done, z_busy} !== 2'b10) begin n_fail++; $display("FAIL b2b_second_hs: got %b expected 10", {z_done, z_busy}); end
    n_checks++; if (z_readData !== 16'h0000) begin n_fail++; $display("FAIL b2b_second_data: got %h expected 0000", z_readData); end
    z_MemRead = 1'b0;
    tick();
    n_checks++; if ({z_done, z_busy} !== 2'b00) begin n_fail++; $display("FAIL b2b_idle_hs: got %b expected 00", {z_done, z_busy}); end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_byte_enable();
    test_write_priority();
    test_misalign();
    test_range();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_ws.md
Name: data_memory_ws

Overview:
- Parametrised, wait-state data memory for the MIPS pipeline MEM stage.
- Generalises the fixed 16x16 data memory with:
  - configurable data width and depth;
  - byte-addressed words and per-byte write enables;
  - programmable access latency with a busy/done handshake that stalls the pipeline;
  - error flags for misaligned and out-of-range accesses.
- Write takes priority over read, as in the existing MEM stage.
- Data preload on reset is unchanged.

Parameters:
- DATA_W, 16, data word width; must be a multiple of 8.
- ADDR_W, 16, byte-address width.
- DEPTH, 64, number of words; must be at least 5.
- WAIT_CYCLES, 2, extra cycles per access, range 0..15.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  byte address.
- wrtData  in  DATA_W  write data.
- byte_en  in  DATA_W/8  per-byte write enable; bit i covers bits [8i+7:8i].
- MemRead  in  1  read request.
- MemWrt  in  1  write request; wins when MemRead is also high.
- readData  out  DATA_W  registered read data.
- busy  out  1  access in progress; the pipeline holds MemRead, MemWrt, address and wrtData stable.
- done  out  1  one-cycle pulse when an access completes.
- misalign_err  out  1  one-cycle pulse, coincident with done.
- range_err  out  1  one-cycle pulse, coincident with done.

Behaviour:
- Reset (rst low, asynchronous):
  - state goes to IDLE; counter is 0.
  - readData, busy, done and both error flags are 0.
  - Memory words 0..4 are loaded with 2BCD, 0000, 1234, DEAD, BEEF (zero-extended to DATA_W). All other words are 0.
  - Reset during WAIT aborts the access: no write is done and no done pulse is issued.
- Addressing:
  - word index = address >> 1 for DATA_W=16; generally address >> log2(DATA_W/8).
  - Low address bits nonzero means misaligned.
  - Word index >= DEPTH means out of range.
- States:
  - IDLE: when MemWrt or MemRead is high at an edge, the request is accepted. Address, data, byte_en and op are latched.
    - WAIT_CYCLES=0: the access executes at that same edge; done goes high for the next cycle; busy stays 0.
    - WAIT_CYCLES>0: go to WAIT with counter = WAIT_CYCLES-1; busy goes to 1.
  - WAIT: new requests are ignored.
    - Counter nonzero: decrement.
    - Counter zero: execute the access on the latched values, return to IDLE, busy goes to 0, done pulses.
- Latency: an access accepted at edge k executes at edge k+WAIT_CYCLES. busy is high for exactly WAIT_CYCLES cycles.
- Access execution:
  - Write: only bytes with byte_en=1 are updated. byte_en all-zero is a no-op but still completes with done. readData is unchanged.
  - Read: readData takes the memory word, held until the next completed read.
  - Misaligned: no memory change; readData unchanged; misalign_err pulses with done.
  - Out of range: write dropped; read returns 0; range_err pulses with done.
  - If both conditions hold, both flags pulse.
- Back-to-back: the done cycle is in IDLE. A request still asserted then is accepted as a new access. The pipeline must drop or advance the request on done.
- Read after write to the same word returns the new data. No bypass exists; accesses are serialised.

Decomposition:
- Package dmem_pkg:
  - state enum: IDLE, WAIT;
  - preload constants PRELOAD_0..PRELOAD_4;
  - function deriving word index and misalign from address.
- Sub-module dmem_array:
  - storage with byte-enabled synchronous write, synchronous read and reset preload;
  - instantiated once.
- The parent holds the FSM, wait counter and error logic.

Test Plan:
- Reset, then read address 6 with WAIT_CYCLES=2:
  - busy is high for 2 cycles;
  - done pulses at edge k+2;
  - readData = DEAD.
- Write address 4 with wrtData=A5A5, byte_en=01, then read address 4:
  - readData = 12A5;
  - a second write with byte_en=00 leaves the word at 12A5 and still pulses done.
- MemRead and MemWrt both high at address 8 with wrtData=CAFE:
  - the write executes and readData is unchanged;
  - a following read returns CAFE.
- Read address 3:
  - misalign_err and done pulse together; readData keeps its prior value.
- Write to address 2*DEPTH:
  - range_err pulses; no word changes.
- Read of address 2*DEPTH:
  - readData = 0000.
- Assert rst mid-WAIT during a write of 1111 to address 0:
  - no done pulse; busy = 0;
  - a subsequent read of address 0 returns 2BCD.
- WAIT_CYCLES=0 build:
  - back-to-back reads of 0 then 2 give done on consecutive cycles;
  - readData = 2BCD, then 0000;
  - busy never asserts.
